// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the E stage.
// Owns architectural HI/LO and raises the MD-class pipeline stall.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDout
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   phi_q, phi_d;
    logic [31:0]   plo_q, plo_d;
    logic          dz_q, dz_d;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic is_mul, is_div, start;

    assign op_mult  = (E_MDop == 4'd1);
    assign op_multu = (E_MDop == 4'd2);
    assign op_div   = (E_MDop == 4'd3);
    assign op_divu  = (E_MDop == 4'd4);
    assign op_mthi  = (E_MDop == 4'd5);
    assign op_mtlo  = (E_MDop == 4'd6);
    assign op_mfhi  = (E_MDop == 4'd7);
    assign op_mflo  = (E_MDop == 4'd8);

    assign is_mul = op_mult | op_multu;
    assign is_div = op_div | op_divu;
    assign start  = (is_mul | is_div) & (state_q == IDLE);

    // Products: low 64 bits of the product of sign-/zero-extended operands.
    logic [63:0] mul_a, mul_b, prod;

    assign mul_a = op_mult ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
    assign mul_b = op_mult ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
    assign prod  = mul_a * mul_b;

    // Division on magnitudes; signs restored afterwards for div.
    logic        a_neg, b_neg, b_zero;
    logic [31:0] abs_a, abs_b, dvd, dvs;
    logic [31:0] uq, ur, quot, rem;
    logic        q_neg, r_neg;

    assign a_neg  = E_A[31];
    assign b_neg  = E_B[31];
    assign b_zero = (E_B == 32'd0);
    assign abs_a  = a_neg ? (32'd0 - E_A) : E_A;
    assign abs_b  = b_neg ? (32'd0 - E_B) : E_B;
    assign dvd    = op_div ? abs_a : E_A;
    assign dvs    = b_zero ? 32'd1 : (op_div ? abs_b : E_B);
    assign uq     = dvd / dvs;
    assign ur     = dvd % dvs;
    assign q_neg  = op_div & (a_neg ^ b_neg);
    assign r_neg  = op_div & a_neg;
    assign quot   = q_neg ? (32'd0 - uq) : uq;
    assign rem    = r_neg ? (32'd0 - ur) : ur;

    // Next-state: start/latch in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    if (is_mul) begin
                        phi_d = prod[63:32];
                        plo_d = prod[31:0];
                        dz_d  = 1'b0;
                        cnt_d = MULT_CNT;
                    end else begin
                        phi_d = rem;
                        plo_d = quot;
                        dz_d  = b_zero;
                        cnt_d = DIV_CNT;
                    end
                end else if (op_mthi) begin
                    hi_d = E_A;
                end else if (op_mtlo) begin
                    lo_d = E_A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset drops any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign md_stall = D_is_md & (start | busy);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign E_MDout  = op_mfhi ? hi_q : (op_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors; commits checked by a scoreboard monitor
// that pops the expected HI/LO each time busy falls.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDop;
    logic [31:0] E_A, E_B;
    logic        D_is_md;
    logic        busy, md_stall;
    logic [31:0] HI, LO, E_MDout;

    int checks = 0;
    int fails  = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MDop(E_MDop), .E_A(E_A), .E_B(E_B),
        .D_is_md(D_is_md), .busy(busy), .md_stall(md_stall),
        .HI(HI), .LO(LO), .E_MDout(E_MDout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        E_MDop = op; E_A = a; E_B = b;
        exp_q.push_back({ehi, elo});
        tick();
        E_MDop = 4'd0;
    endtask

    task automatic wait_idle(output int n, output int s);
        n = 0; s = 0;
        while (busy && n < 100) begin
            n++;
            if (md_stall) s++;
            tick();
        end
        if (n >= 100) begin
            fails++; checks++;
            $display("FAIL wait_idle: busy stuck after %0d cycles", n);
        end
    endtask

    // Monitor: on each legitimate busy fall, compare HI/LO with the next expected.
    initial begin : monitor
        logic prev_busy, prev_rst;
        logic [63:0] e;
        prev_busy = 1'b0; prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy && !prev_rst) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL commit: unexpected commit HI=%h LO=%h", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_HI", HI, e[63:32]);
                    chk("commit_LO", LO, e[31:0]);
                end
            end
            prev_busy = busy;
            prev_rst  = reset;
        end
    end

    initial begin : stim
        int n, s;
        reset = 1'b1; E_MDop = 4'd0; E_A = '0; E_B = '0; D_is_md = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_HI", HI, 32'd0);
        chk("reset_LO", LO, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);

        // Reset mid-RUN: mult 5*7 aborted, nothing committed.
        E_MDop = 4'd1; E_A = 32'd5; E_B = 32'd7;
        tick();
        E_MDop = 4'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_HI", HI, 32'd0);
        chk("rst_run_LO", LO, 32'd0);
        repeat (8) tick();
        chk("rst_nocommit_LO", LO, 32'd0);
        chk("rst_nocommit_busy", {31'd0, busy}, 32'd0);

        // mult -2*3, no D-stage MD op: stall must stay low.
        D_is_md = 1'b0;
        start_op(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        wait_idle(n, s);
        chk("mult_busy_cycles", n, 32'd5);
        chk("mult_stall_cnt", s, 32'd0);

        // multu same operands.
        start_op(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        wait_idle(n, s);
        chk("multu_busy_cycles", n, 32'd5);

        // div -7/2 with D_is_md high: stall on start cycle plus 10 busy cycles.
        D_is_md = 1'b1;
        E_MDop = 4'd3; E_A = 32'hFFFFFFF9; E_B = 32'd2;
        #1;
        chk("div_stall_start", {31'd0, md_stall}, 32'd1);
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        tick();
        E_MDop = 4'd0;
        wait_idle(n, s);
        chk("div_busy_cycles", n, 32'd10);
        chk("div_stall_busy", s, 32'd10);
        chk("div_stall_12th", {31'd0, md_stall}, 32'd0);
        D_is_md = 1'b0;

        // mthi/mtlo in IDLE, then divu by zero leaves HI/LO untouched.
        E_MDop = 4'd5; E_A = 32'h11;
        tick();
        E_MDop = 4'd6; E_A = 32'h22;
        tick();
        E_MDop = 4'd0;
        chk("mthi_idle", HI, 32'h11);
        chk("mtlo_idle", LO, 32'h22);
        start_op(4'd4, 32'd7, 32'd0, 32'h11, 32'h22);
        wait_idle(n, s);
        chk("divu0_busy_cycles", n, 32'd10);

        // mthi 0xABCD in IDLE.
        E_MDop = 4'd5; E_A = 32'hABCD;
        tick();
        E_MDop = 4'd0;
        chk("mthi_HI", HI, 32'hABCD);
        chk("mthi_busy", {31'd0, busy}, 32'd0);

        // Overflow div; mfhi during RUN sees old HI, mtlo during RUN ignored.
        start_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        E_MDop = 4'd7;
        #1;
        chk("mfhi_run", E_MDout, 32'hABCD);
        tick();
        E_MDop = 4'd6; E_A = 32'h1234;
        tick();
        E_MDop = 4'd8;
        #1;
        chk("mtlo_run_ignored", LO, 32'h22);
        chk("mflo_run", E_MDout, 32'h22);
        E_MDop = 4'd0;
        wait_idle(n, s);

        // Back-to-back mult: second start accepted the cycle busy drops.
        start_op(4'd1, 32'h00010000, 32'h00010000, 32'h1, 32'h0);
        wait_idle(n, s);
        start_op(4'd1, 32'd6, 32'd7, 32'h0, 32'd42);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_idle(n, s);
        chk("b2b_busy_cycles", n, 32'd5);

        // divu 100/7 and mflo read.
        start_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
        wait_idle(n, s);
        E_MDop = 4'd8;
        #1;
        chk("mflo_idle", E_MDout, 32'd14);
        E_MDop = 4'd0;
        #1;
        chk("mdout_none", E_MDout, 32'd0);

        tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
